mp_proc: RTL and testbench

- Magnitude/phase feedback processor for the RF control loop.
- Input is a time-multiplexed magnitude/phase stream; X is the magnitude word and Y is the phase word.
- Per axis it computes a setpoint error, runs a PI controller with a clamped integrator, and adds optional feedforward terms.
- Output is a time-multiplexed drive stream (X then Y) plus an offset phase word, feeding the downstream drive/rotation stage.

---
 rtl/mp_proc.sv | 174 +++++++++++++++++
 tb/tb_mp_proc.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mp_proc.sv
// Magnitude/phase PI feedback processor: per-axis setpoint error, clamped integrator,
// proportional term and feedforward offsets, producing a muxed X/Y drive stream.
module mp_proc #(
    parameter int SHIFT = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync,
    input  logic signed [17:0] in_mp,
    input  logic               sel_en,
    input  logic signed [17:0] ph_offset,
    input  logic signed [17:0] setmp_x,
    input  logic signed [17:0] setmp_y,
    input  logic signed [17:0] coeff_xi,
    input  logic signed [17:0] coeff_yi,
    input  logic signed [17:0] coeff_xp,
    input  logic signed [17:0] coeff_yp,
    input  logic signed [17:0] lim_x_hi,
    input  logic signed [17:0] lim_y_hi,
    input  logic signed [17:0] lim_x_lo,
    input  logic signed [17:0] lim_y_lo,
    input  logic               ffd_en,
    input  logic signed [17:0] ff_setm,
    input  logic signed [17:0] ff_setp,
    input  logic signed [17:0] ff_ddrive,
    input  logic signed [17:0] ff_dphase,
    input  logic               ffp_en,
    input  logic signed [17:0] ff_drive,
    input  logic signed [17:0] ff_phase,
    output logic signed [17:0] out_xy,
    output logic signed [18:0] out_ph,
    output logic               out_sync
);
    localparam int PW = 37;
    localparam int SW = 40;
    localparam logic signed [SW-1:0] SAT_MAX = 40'sd131071;
    localparam logic signed [SW-1:0] SAT_MIN = -40'sd131072;

    function automatic logic signed [PW-1:0] gain_scale(input logic signed [18:0] err,
                                                        input logic signed [17:0] coef);
        logic signed [PW-1:0] prod;
        prod = PW'(err) * PW'(coef);
        return prod >>> SHIFT;
    endfunction

    // Upper limit first, then lower, so lo wins when the limits cross.
    function automatic logic signed [17:0] integ_clamp(input logic signed [17:0] integ,
                                                       input logic signed [PW-1:0] iterm,
                                                       input logic signed [17:0] ffd,
                                                       input logic signed [17:0] hi,
                                                       input logic signed [17:0] lo);
        logic signed [SW-1:0] sum;
        sum = SW'(integ) + SW'(iterm) + SW'(ffd);
        if (sum > SW'(hi)) sum = SW'(hi);
        if (sum < SW'(lo)) sum = SW'(lo);
        return 18'(sum);
    endfunction

    function automatic logic signed [17:0] sat18(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) return 18'sh1ffff;
        if (v < SAT_MIN) return 18'sh20000;
        return 18'(v);
    endfunction

    function automatic logic signed [17:0] drive_sum(input logic signed [17:0] integ,
                                                     input logic signed [PW-1:0] pterm,
                                                     input logic signed [17:0] ffp);
        return sat18(SW'(integ) + SW'(pterm) + SW'(ffp));
    endfunction

    logic vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q, out_sync_q;
    logic signed [17:0] x_p0_q, x_p0_d, y_p1_q, y_p1_d;
    logic signed [18:0] err_x_p2_q, err_x_p2_d, err_y_p2_q, err_y_p2_d;
    logic signed [PW-1:0] pi_x_p3_q, pi_x_p3_d, pi_y_p3_q, pi_y_p3_d;
    logic signed [PW-1:0] pp_x_p3_q, pp_x_p3_d, pp_y_p3_q, pp_y_p3_d;
    logic signed [17:0] integ_x_q, integ_x_d, integ_y_q, integ_y_d;
    logic signed [17:0] out_xy_q, out_xy_d, out_y_q, out_y_d;
    logic signed [18:0] out_ph_q, out_ph_d;
    logic signed [17:0] set_x, set_y;

    always_comb begin
        set_x = ffd_en ? ff_setm : setmp_x;
        set_y = ffd_en ? ff_setp : setmp_y;

        // p0: X word captured on sync, Y word on the following cycle
        x_p0_d = sync ? in_mp : x_p0_q;
        y_p1_d = vld_p0_q ? in_mp : y_p1_q;

        // p1: setpoint error
        err_x_p2_d = err_x_p2_q;
        err_y_p2_d = err_y_p2_q;
        if (vld_p1_q) begin
            err_x_p2_d = sel_en ? (19'(x_p0_q) - 19'(set_x)) : '0;
            err_y_p2_d = sel_en ? (19'(y_p1_q) - 19'(set_y)) : '0;
        end

        // p2: gain products
        pi_x_p3_d = pi_x_p3_q;
        pi_y_p3_d = pi_y_p3_q;
        pp_x_p3_d = pp_x_p3_q;
        pp_y_p3_d = pp_y_p3_q;
        if (vld_p2_q) begin
            pi_x_p3_d = gain_scale(err_x_p2_q, coeff_xi);
            pi_y_p3_d = gain_scale(err_y_p2_q, coeff_yi);
            pp_x_p3_d = gain_scale(err_x_p2_q, coeff_xp);
            pp_y_p3_d = gain_scale(err_y_p2_q, coeff_yp);
        end

        // p3: integrator update
        integ_x_d = integ_x_q;
        integ_y_d = integ_y_q;
        if (vld_p3_q) begin
            integ_x_d = integ_clamp(integ_x_q, pi_x_p3_q, ffd_en ? ff_ddrive : 18'sd0,
                                    lim_x_hi, lim_x_lo);
            integ_y_d = integ_clamp(integ_y_q, pi_y_p3_q, ffd_en ? ff_dphase : 18'sd0,
                                    lim_y_hi, lim_y_lo);
        end

        // p4: output sums; X goes out first, Y is parked for the next cycle
        out_xy_d = out_xy_q;
        out_y_d  = out_y_q;
        out_ph_d = out_ph_q;
        if (vld_p4_q) begin
            out_xy_d = drive_sum(integ_x_q, pp_x_p3_q, ffp_en ? ff_drive : 18'sd0);
            out_y_d  = drive_sum(integ_y_q, pp_y_p3_q, ffp_en ? ff_phase : 18'sd0);
            out_ph_d = 19'(y_p1_q) + 19'(ph_offset);
        end else if (out_sync_q) begin
            out_xy_d = out_y_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0_q   <= 1'b0;
            vld_p1_q   <= 1'b0;
            vld_p2_q   <= 1'b0;
            vld_p3_q   <= 1'b0;
            vld_p4_q   <= 1'b0;
            out_sync_q <= 1'b0;
            integ_x_q  <= '0;
            integ_y_q  <= '0;
            out_xy_q   <= '0;
            out_ph_q   <= '0;
        end else begin
            vld_p0_q   <= sync;
            vld_p1_q   <= vld_p0_q;
            vld_p2_q   <= vld_p1_q;
            vld_p3_q   <= vld_p2_q;
            vld_p4_q   <= vld_p3_q;
            out_sync_q <= vld_p4_q;
            integ_x_q  <= integ_x_d;
            integ_y_q  <= integ_y_d;
            out_xy_q   <= out_xy_d;
            out_ph_q   <= out_ph_d;
        end
    end

    always_ff @(posedge clk) begin
        x_p0_q     <= x_p0_d;
        y_p1_q     <= y_p1_d;
        err_x_p2_q <= err_x_p2_d;
        err_y_p2_q <= err_y_p2_d;
        pi_x_p3_q  <= pi_x_p3_d;
        pi_y_p3_q  <= pi_y_p3_d;
        pp_x_p3_q  <= pp_x_p3_d;
        pp_y_p3_q  <= pp_y_p3_d;
        out_y_q    <= out_y_d;
    end

    assign out_xy   = out_xy_q;
    assign out_ph   = out_ph_q;
    assign out_sync = out_sync_q;

endmodule

// File: tb/tb_mp_proc.sv
// Bench for mp_proc: directed loop scenarios plus randomized frames, all compared
// against a frame-level arithmetic model of the controller.
module tb_mp_proc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sync = 1'b0;
    logic sel_en = 1'b0, ffd_en = 1'b0, ffp_en = 1'b0;
    logic signed [17:0] in_mp = '0, ph_offset = '0;
    logic signed [17:0] setmp_x = '0, setmp_y = '0;
    logic signed [17:0] coeff_xi = '0, coeff_yi = '0, coeff_xp = '0, coeff_yp = '0;
    logic signed [17:0] lim_x_hi = '0, lim_y_hi = '0, lim_x_lo = '0, lim_y_lo = '0;
    logic signed [17:0] ff_setm = '0, ff_setp = '0, ff_ddrive = '0, ff_dphase = '0;
    logic signed [17:0] ff_drive = '0, ff_phase = '0;
    logic signed [17:0] out_xy;
    logic signed [18:0] out_ph;
    logic out_sync;

    mp_proc #(.SHIFT(12)) dut (
        .clk(clk), .rst_n(rst_n), .sync(sync), .in_mp(in_mp), .sel_en(sel_en),
        .ph_offset(ph_offset), .setmp_x(setmp_x), .setmp_y(setmp_y),
        .coeff_xi(coeff_xi), .coeff_yi(coeff_yi), .coeff_xp(coeff_xp), .coeff_yp(coeff_yp),
        .lim_x_hi(lim_x_hi), .lim_y_hi(lim_y_hi), .lim_x_lo(lim_x_lo), .lim_y_lo(lim_y_lo),
        .ffd_en(ffd_en), .ff_setm(ff_setm), .ff_setp(ff_setp),
        .ff_ddrive(ff_ddrive), .ff_dphase(ff_dphase), .ffp_en(ffp_en),
        .ff_drive(ff_drive), .ff_phase(ff_phase),
        .out_xy(out_xy), .out_ph(out_ph), .out_sync(out_sync)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    longint m_integ[2];
    longint exp_x, exp_y, exp_ph;
    longint obs_x, obs_y;
    int plan_hi[5] = '{0, 1500, 1500, 1500, 500};
    int plan_lo[5] = '{0, 0, 1000, 0, 0};
    int plan_x[5]  = '{0, 0, 1000, 1000, 500};

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div4096(input longint a);
        longint q;
        q = a / 4096;
        if ((a % 4096) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint sat18(input longint v);
        if (v > 131071) return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic int rnd18();
        logic signed [17:0] r;
        r = 18'($urandom);
        return int'(r);
    endfunction

    function automatic int rnd_small(input int span);
        return int'($urandom_range(0, 2 * span)) - span;
    endfunction

    task automatic model_frame(input int x, input int y);
        longint inp[2], set[2], ci[2], cp[2], hi[2], lo[2], ffd[2], ffp[2], o[2];
        longint err, s;
        inp = '{x, y};
        set = ffd_en ? '{longint'(ff_setm), longint'(ff_setp)} : '{longint'(setmp_x), longint'(setmp_y)};
        ci  = '{longint'(coeff_xi), longint'(coeff_yi)};
        cp  = '{longint'(coeff_xp), longint'(coeff_yp)};
        hi  = '{longint'(lim_x_hi), longint'(lim_y_hi)};
        lo  = '{longint'(lim_x_lo), longint'(lim_y_lo)};
        ffd = '{longint'(ff_ddrive), longint'(ff_dphase)};
        ffp = '{longint'(ff_drive), longint'(ff_phase)};
        for (int a = 0; a < 2; a++) begin
            err = sel_en ? inp[a] - set[a] : 0;
            s = m_integ[a] + floor_div4096(err * ci[a]) + (ffd_en ? ffd[a] : 0);
            if (s > hi[a]) s = hi[a];
            if (s < lo[a]) s = lo[a];
            m_integ[a] = s;
            o[a] = sat18(s + floor_div4096(err * cp[a]) + (ffp_en ? ffp[a] : 0));
        end
        exp_x  = o[0];
        exp_y  = o[1];
        exp_ph = longint'(y) + longint'(ph_offset);
    endtask

    task automatic run_frame(input int x, input int y, input string tag);
        int found;
        model_frame(x, y);
        found = -1;
        @(posedge clk); #1;
        sync  = 1'b1;
        in_mp = 18'(x);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (found >= 0 && k == found + 1) begin
                obs_y = longint'(out_xy);
                chk({tag, "_y"}, obs_y, exp_y);
                chk({tag, "_sync_pulse"}, longint'(out_sync), 0);
            end
            if (out_sync && found < 0) begin
                found = k;
                obs_x = longint'(out_xy);
                chk({tag, "_x"}, obs_x, exp_x);
                chk({tag, "_ph"}, longint'(out_ph), exp_ph);
            end
            @(posedge clk); #1;
            sync  = 1'b0;
            in_mp = (k == 0) ? 18'(y) : 18'($urandom);
        end
        chk({tag, "_latency"}, found, 6);
    endtask

    initial begin
        int seen;
        m_integ = '{0, 0};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_xy", longint'(out_xy), 0);
        chk("reset_out_ph", longint'(out_ph), 0);
        chk("reset_out_sync", longint'(out_sync), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // limits alone move a zero-gain integrator
        sel_en  = 1'b1;
        setmp_x = 18'sd100;
        for (int i = 0; i < 5; i++) begin
            lim_x_hi = 18'(plan_hi[i]);
            lim_x_lo = 18'(plan_lo[i]);
            run_frame(1000, 2000, "clamp");
            chk("clamp_plan", obs_x, plan_x[i]);
        end

        ffd_en = 1'b1; ffp_en = 1'b1;
        ff_setm = 18'sd200; coeff_xi = 18'sd1800; lim_x_hi = 18'sd2500; lim_x_lo = 18'sd0;
        for (int i = 0; i < 8; i++) begin
            run_frame(1000, 2000, "idrive");
            if (i == 0) chk("idrive_step", obs_x, 851);
        end
        chk("idrive_settle", obs_x, 2500);

        lim_y_hi = 18'sd500; lim_y_lo = -18'sd1000; coeff_yi = 18'sd450;
        for (int i = 0; i < 3; i++) run_frame(1000, 2000, "ypre");
        chk("ypre_top", obs_y, 500);
        coeff_yi = -18'sd450;
        for (int i = 0; i < 2; i++) run_frame(1000, 2000, "ystep");
        chk("ystep_two", obs_y, 60);
        for (int i = 0; i < 6; i++) run_frame(1000, 2000, "ystep");
        chk("ystep_floor", obs_y, -1000);

        ff_setm = 18'sd1000; lim_x_hi = 18'sd3500;
        for (int i = 0; i < 3; i++) run_frame(1000, 2000, "zerr");
        chk("zerr_hold", obs_x, 2500);

        ff_drive = 18'sd50; ff_phase = 18'sd50;
        run_frame(1000, 2000, "ffp");
        chk("ffp_x", obs_x, 2550);
        chk("ffp_y", obs_y, -950);
        ff_drive = 18'sd0; ff_phase = 18'sd0;
        run_frame(1000, 2000, "ffp_off");
        chk("ffp_off_x", obs_x, 2500);
        chk("ffp_off_y", obs_y, -1000);

        ff_ddrive = 18'sd30;
        run_frame(1000, 2000, "ffd");
        chk("ffd_first", obs_x, 2530);
        run_frame(1000, 2000, "ffd");
        chk("ffd_second", obs_x, 2560);
        for (int i = 0; i < 34; i++) run_frame(1000, 2000, "ffd");
        chk("ffd_limit", obs_x, 3500);

        // frame in flight across a reset is dropped
        @(posedge clk); #1; sync = 1'b1; in_mp = 18'sd1234;
        @(posedge clk); #1; sync = 1'b0; in_mp = 18'sd4321;
        @(posedge clk); #1; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_integ = '{0, 0};
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_sync) seen++;
        end
        chk("rst_discard", seen, 0);
        chk("rst_cleared_xy", longint'(out_xy), 0);
        run_frame(1000, 2000, "post_rst");

        for (int n = 0; n < 60; n++) begin
            sel_en = 1'($urandom); ffd_en = 1'($urandom); ffp_en = 1'($urandom);
            ph_offset = 18'(rnd18());
            setmp_x = 18'(rnd_small(3000)); setmp_y = 18'(rnd_small(3000));
            ff_setm = 18'(rnd_small(3000)); ff_setp = 18'(rnd_small(3000));
            coeff_xi = 18'(($urandom_range(0, 3) == 0) ? rnd18() : rnd_small(4000));
            coeff_yi = 18'(($urandom_range(0, 3) == 0) ? rnd18() : rnd_small(4000));
            coeff_xp = 18'(($urandom_range(0, 3) == 0) ? rnd18() : rnd_small(4000));
            coeff_yp = 18'(($urandom_range(0, 3) == 0) ? rnd18() : rnd_small(4000));
            lim_x_hi = 18'(rnd18()); lim_x_lo = 18'(rnd_small(60000) - 60000);
            lim_y_hi = 18'(rnd_small(60000) + 60000); lim_y_lo = 18'(rnd18());
            ff_ddrive = 18'(rnd_small(500)); ff_dphase = 18'(rnd_small(500));
            ff_drive = 18'(rnd18()); ff_phase = 18'(rnd_small(2000));
            run_frame(rnd18(), rnd18(), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
